instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream stage of control_unit: holds a small writable program memory and sequences a program counter.
- Hands 8-bit instructions to control_unit over a valid/ready handshake, replacing the switch-driven instruction input.
- Instruction format: bit7 = mode, bits6:4 = opcode, bits3:2 = RegA, bits1:0 = RegB. Only the HALT encoding (and JMP, when the optional feature below is compiled in) is interpreted locally.

Parameters:
- DEPTH, 16, number of program words; must be a power of two, at least 2.
- IW, 8, instruction width in bits.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- prog_we  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  log2(DEPTH)  program write address.
- prog_data  in  IW  program write data.
- start  in  1  one-cycle pulse; begins or restarts fetching.
- instr_out  out  IW  instruction presented to control_unit.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  control_unit accepts instr_out this cycle.
- pc_out  out  log2(DEPTH)  current program counter, for HEX display.
- halted  out  1  HALT reached.

Behaviour:
- Reset values: state IDLE, pc=0, instr_out=0, instr_valid=0, halted=0. Memory contents are not reset.
- Reset asserted in any state, including mid-handshake, returns these values on the next edge. Program is retained.
- FSM states: IDLE, ADDR, DATA, VALID, HALTED.
- IDLE:
  - prog_we writes mem[prog_addr] <= prog_data.
  - start moves to ADDR with the current pc.
  - If prog_we and start occur in the same cycle, the write happens and the subsequent read observes it.
- ADDR: memory read address = pc (synchronous read, 1-cycle latency). Always goes to DATA.
- DATA: memory output is decoded.
  - HALT (bit7=1, opcode 111, low 4 bits don't-care): go to HALTED, set halted=1. pc unchanged (still points at HALT). Not forwarded; instr_valid stays 0.
  - Otherwise: instr_out <= mem data, instr_valid <= 1, go to VALID.
- VALID:
  - instr_out and instr_valid are held stable while instr_ready=0 (no timeout).
  - On instr_valid & instr_ready: instr_valid <= 0, pc <= pc+1 modulo DEPTH (wraps DEPTH-1 to 0), go to ADDR.
- HALTED: halted held at 1. start sets pc <= 0, clears halted, and goes to ADDR.
- start is ignored in ADDR, DATA and VALID. prog_we is ignored in every state other than IDLE.
- Latency and throughput:
  - start to instr_valid: 3 cycles (start edge into ADDR, then DATA, then VALID).
  - Best-case throughput: one instruction per 3 cycles, which exceeds what control_unit's 4-state F/D/E/W cycle consumes.
- pc_out always equals the pc register.

Optional Feature:
- Macro: INSTR_FETCH_JUMP_EN.
- Defined: in DATA, encoding bit7=1, opcode 110 is JMP.
  - pc <= instr[3:0], truncated or zero-extended to log2(DEPTH) bits.
  - Go to ADDR. Not forwarded; no handshake occurs.
  - HALT check takes precedence only for opcode 111, so there is no overlap.
- Undefined: opcode 110 with bit7=1 is forwarded to control_unit like any other instruction.

Decomposition:
- Shared package fetch_pkg:
  - State enum.
  - Constants OP_HALT=3'b111 and OP_JMP=3'b110.
  - Field positions: MODE_BIT=7, OPC_MSB=6, OPC_LSB=4.
  - Default IW=8.
  - control_unit imports the same field constants.
- One sub-module, instr_mem: DEPTH x IW single-port-write, synchronous-read memory with a registered output and no reset. This infers block RAM on the FPGA.

Test Plan:
- Load [30,30,10,F0] in IDLE, pulse start, hold instr_ready=1 → instr_out sequence 30,30,10, each pulse exactly one cycle valid. Then halted=1, pc_out=3, instr_valid=0.
- Same program, instr_ready=0 for 5 cycles after first valid → instr_out=30 and instr_valid=1 held all 5 cycles, pc_out=0. On ready, pc_out becomes 1.
- Fill all 16 words with 30 (no HALT), ready=1, count 16 accepts → pc_out wraps to 0, and the 17th instruction is 30.
- Reset pulsed while in VALID → next cycle instr_valid=0, pc_out=0, state IDLE. Start again → first instruction re-fetched from address 0 (memory intact).
- prog_we to address 0 with data 20 while in VALID → ignored. After HALT and restart, word 0 is still 30. prog_we with start in the same IDLE cycle → the new word is the first fetched.
- With INSTR_FETCH_JUMP_EN, program [30,E0] → 30 forwarded repeatedly, E0 never forwarded, pc_out toggles 0/1. Without the macro → 30, E0, then 30 again (after the pc walks and wraps through zeroed words only if loaded; load addresses 2..15 with 30).

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and instruction-field constants shared by instr_fetch,
// its memory and control_unit.
//   fetch_state_e : fetch sequencer states
//   OP_HALT/OP_JMP: opcodes interpreted locally by the fetch stage
//   MODE_BIT, OPC_MSB, OPC_LSB: instruction field positions
//   IW_DEFAULT    : default instruction width
package fetch_pkg;

  localparam int IW_DEFAULT = 8;

  localparam int MODE_BIT = 7;
  localparam int OPC_MSB  = 6;
  localparam int OPC_LSB  = 4;

  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [2:0] OP_JMP  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_VALID,
    ST_HALTED
  } fetch_state_e;

  // True when the instruction has mode=1 and the given opcode.
  function automatic logic is_mode_op(input logic [7:0] instr, input logic [2:0] op);
    return instr[MODE_BIT] && (instr[OPC_MSB:OPC_LSB] == op);
  endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// instr_mem: DEPTH x IW program store, single write port, synchronous read
// with a registered output and no reset, so it maps onto block RAM.
// Ports:
//   i_clk     : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address, data appears on o_rd_data one cycle later
//   o_rd_data : registered read data
module instr_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [IW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [IW-1:0] o_rd_data
);

  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program memory plus PC sequencer feeding control_unit with
// 8-bit instructions over a valid/ready handshake.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   prog_we/addr/data    : program load port, only honoured in IDLE
//   start                : begin fetching (IDLE) or restart from 0 (HALTED)
//   instr_out/instr_valid: instruction offered to control_unit
//   instr_ready          : control_unit accepts the offered instruction
//   pc_out               : current program counter
//   halted               : a HALT instruction was reached
// Build option:
//   INSTR_FETCH_JUMP_EN  : decode mode=1/opcode 110 as a local jump to
//                          instr[3:0] instead of forwarding it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | program loading allowed, waiting for start
// ADDR    | memory read issued at pc
// DATA    | read data available, decode HALT/JMP or forward
// VALID   | instruction offered, held until instr_ready
// HALTED  | HALT reached, waiting for start to restart at address 0
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = IW_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc_out,
  output logic          halted
);

  fetch_state_e  r_state;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_instr;
  logic          r_valid;
  logic          r_halted;

  logic          w_mem_we;
  logic [IW-1:0] w_rd_data;
  logic          w_is_halt;
  logic          w_is_jmp;
  logic [AW-1:0] w_jmp_tgt;

  assign w_mem_we = (r_state == ST_IDLE) && prog_we;

  // The read address is the pc itself; pc is stable across ADDR and DATA,
  // so the registered memory output seen in DATA is mem[pc].
  instr_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (prog_addr),
    .i_wr_data (prog_data),
    .i_rd_addr (r_pc),
    .o_rd_data (w_rd_data)
  );

  assign w_is_halt = is_mode_op(w_rd_data[7:0], OP_HALT);

`ifdef INSTR_FETCH_JUMP_EN
  assign w_is_jmp = is_mode_op(w_rd_data[7:0], OP_JMP);
`else
  assign w_is_jmp = 1'b0;
`endif

  // Jump target field is 4 bits; narrower or wider pc gets truncated or
  // zero-extended.
  assign w_jmp_tgt = AW'(w_rd_data[3:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALTED;
          end else if (w_is_jmp) begin
            r_pc    <= w_jmp_tgt;
            r_state <= ST_ADDR;
          end else begin
            r_instr <= w_rd_data;
            r_valid <= 1'b1;
            r_state <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_pc    <= r_pc + AW'(1);
            r_state <= ST_ADDR;
          end
        end
        ST_HALTED: begin
          if (start) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_state  <= ST_ADDR;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int DEPTH = 16;
  localparam int IW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc_out;
  logic          halted;

  instr_fetch #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a launch (start or accept) yields the fetched word two
  // edges later; a HALT word stops, a JMP word relaunches at its target.
  logic [IW-1:0] m_mem [DEPTH];
  int            m_pc = 0;
  int            m_cnt = 0;
  bit            m_idle = 1'b1;
  bit            m_halted = 1'b0;
  bit            m_valid = 1'b0;
  logic [IW-1:0] m_instr = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  end

  always @(posedge clk) begin : model
    int            pc, cnt;
    bit            idl, hlt, vld;
    logic [IW-1:0] ins, w;
    pc = m_pc; cnt = m_cnt; idl = m_idle; hlt = m_halted; vld = m_valid; ins = m_instr;
    if (reset) begin
      pc = 0; cnt = 0; idl = 1; hlt = 0; vld = 0; ins = '0;
    end else if (idl) begin
      if (prog_we) m_mem[prog_addr] <= prog_data;
      if (start) begin idl = 0; cnt = 2; end
    end else if (hlt) begin
      if (start) begin hlt = 0; pc = 0; cnt = 2; end
    end else if (vld) begin
      if (instr_ready) begin vld = 0; pc = (pc + 1) % DEPTH; cnt = 2; end
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        w = m_mem[pc];
        if (w[7:4] == 4'hF) hlt = 1;
`ifdef INSTR_FETCH_JUMP_EN
        else if (w[7:4] == 4'hE) begin pc = int'(w[3:0]) % DEPTH; cnt = 2; end
`endif
        else begin vld = 1; ins = w; end
      end
    end
    m_pc <= pc; m_cnt <= cnt; m_idle <= idl; m_halted <= hlt; m_valid <= vld; m_instr <= ins;
  end

  bit            cmp_en = 1'b0;
  int            valid_cycles = 0;
  int            pc_max = 0;
  logic [IW-1:0] acc_q[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_valid", instr_valid, m_valid);
      check("model_pc", pc_out, m_pc);
      check("model_halted", halted, m_halted);
      check("model_instr", instr_out, m_instr);
      if (instr_valid) valid_cycles++;
      if (instr_valid && instr_ready) acc_q.push_back(instr_out);
      if (int'(pc_out) > pc_max) pc_max = int'(pc_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin tick(); n++; end
    if (!instr_valid) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin tick(); n++; end
    if (!halted) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_accepts(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (acc_q.size() < cnt && n < budget) begin tick(); n++; end
    if (acc_q.size() < cnt) check(name, acc_q.size(), cnt);
  endtask

  logic [IW-1:0] exp_seq [6];

  initial begin
    // reset state
    reset = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_pc", pc_out, 4'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_instr", instr_out, 8'h00);
    reset = 1'b0;

    // basic program ending in HALT
    write_word(0, 8'h30);
    write_word(1, 8'h30);
    write_word(2, 8'h10);
    write_word(3, 8'hF0);
    instr_ready = 1'b1;
    acc_q.delete();
    valid_cycles = 0;
    pulse_start();
    check("lat_addr", instr_valid, 1'b0);
    tick();
    check("lat_data", instr_valid, 1'b0);
    tick();
    check("lat_valid", instr_valid, 1'b1);
    wait_halted("halt_timeout", 30);
    tick();
    check("seq_len", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("seq0", acc_q[0], 8'h30);
      check("seq1", acc_q[1], 8'h30);
      check("seq2", acc_q[2], 8'h10);
    end
    check("valid_cycles", valid_cycles, 3);
    check("halt_pc", pc_out, 4'd3);
    check("halt_flag", halted, 1'b1);
    check("halt_valid", instr_valid, 1'b0);

    // back-pressure, ignored prog_we/start while in VALID
    do_reset();
    instr_ready = 1'b0;
    pulse_start();
    wait_valid("bp_timeout", 10);
    for (int i = 0; i < 5; i++) begin
      check("bp_instr", instr_out, 8'h30);
      check("bp_valid", instr_valid, 1'b1);
      check("bp_pc", pc_out, 4'd0);
      if (i == 0) begin
        prog_we = 1'b1; prog_addr = '0; prog_data = 8'h20; start = 1'b1;
      end
      tick();
      prog_we = 1'b0; start = 1'b0;
    end
    instr_ready = 1'b1;
    tick();
    check("bp_pc_after", pc_out, 4'd1);
    check("bp_valid_after", instr_valid, 1'b0);
    wait_halted("bp_halt_timeout", 30);
    pulse_start();
    check("restart_pc", pc_out, 4'd0);
    check("restart_halted", halted, 1'b0);
    wait_valid("restart_timeout", 10);
    check("word0_kept", instr_out, 8'h30);

    // full memory, pc wrap
    do_reset();
    for (int a = 0; a < DEPTH; a++) write_word(a, 8'h30);
    acc_q.delete();
    instr_ready = 1'b1;
    pulse_start();
    wait_accepts("wrap_timeout", 16, 80);
    check("wrap_pc", pc_out, 4'd0);
    wait_valid("wrap17_timeout", 10);
    check("wrap_17th", instr_out, 8'h30);

    // reset mid-handshake, memory retained
    instr_ready = 1'b0;
    wait_valid("midrst_timeout", 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_pc", pc_out, 4'd0);
    check("midrst_halted", halted, 1'b0);
    pulse_start();
    wait_valid("refetch_timeout", 10);
    check("refetch", instr_out, 8'h30);

    // write and start in the same IDLE cycle
    do_reset();
    prog_we = 1'b1; prog_addr = '0; prog_data = 8'h20; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_valid("we_start_timeout", 10);
    check("we_with_start", instr_out, 8'h20);

    // opcode 110 handling
    do_reset();
    write_word(0, 8'h30);
    write_word(1, 8'hE0);
    for (int a = 2; a < DEPTH; a++) write_word(a, 8'h30);
    acc_q.delete();
    pc_max = 0;
    instr_ready = 1'b1;
    pulse_start();
    wait_accepts("jmp_timeout", 6, 60);
`ifdef INSTR_FETCH_JUMP_EN
    exp_seq = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    check("jmp_pc_max", pc_max, 1);
`else
    exp_seq = '{8'h30, 8'hE0, 8'h30, 8'h30, 8'h30, 8'h30};
    check("nojmp_pc_max", pc_max, 5);
`endif
    if (acc_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("op110_seq", acc_q[i], exp_seq[i]);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
